// File: rtl/rsc_encoder.sv
// LTE constituent RSC encoder: one (sys, par) pair per accepted bit, then three
// termination pairs; one-cycle latency, output register stalls input when out_ready is low.
module rsc_encoder #(
    parameter int KMAX = 6144,
    parameter int LW   = 13
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          start,
    input  logic [LW-1:0] frame_len,
    output logic          len_err,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_bit,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_sys,
    output logic          out_par,
    output logic          out_tail,
    output logic          out_last,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, DATA, TAIL, FLUSH} state_t;

    state_t        state_q, state_d;
    logic          s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic [LW-1:0] k_q, k_d;
    logic [1:0]    tail_cnt_q, tail_cnt_d;
    logic          out_valid_q, out_valid_d;
    logic          out_sys_q, out_sys_d;
    logic          out_par_q, out_par_d;
    logic          out_tail_q, out_tail_d;
    logic          out_last_q, out_last_d;
    logic          len_err_q, len_err_d;

    logic          load_ok;
    logic          fb_a;

    // The output register may be reloaded when empty or drained this cycle.
    assign load_ok  = !out_valid_q || out_ready;
    assign in_ready = !Reset && (state_q == DATA) && load_ok;
    assign busy     = !Reset && (state_q != IDLE);
    assign fb_a     = in_bit ^ s2_q ^ s3_q;

    always_comb begin
        state_d     = state_q;
        s1_d        = s1_q;
        s2_d        = s2_q;
        s3_d        = s3_q;
        cnt_d       = cnt_q;
        k_d         = k_q;
        tail_cnt_d  = tail_cnt_q;
        out_valid_d = out_valid_q;
        out_sys_d   = out_sys_q;
        out_par_d   = out_par_q;
        out_tail_d  = out_tail_q;
        out_last_d  = out_last_q;
        len_err_d   = 1'b0;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (frame_len >= LW'(40) && frame_len <= LW'(KMAX)) begin
                        k_d        = frame_len;
                        s1_d       = 1'b0;
                        s2_d       = 1'b0;
                        s3_d       = 1'b0;
                        cnt_d      = '0;
                        tail_cnt_d = '0;
                        state_d    = DATA;
                    end else begin
                        len_err_d = 1'b1;
                    end
                end
            end
            DATA: begin
                if (in_valid && in_ready) begin
                    s1_d        = fb_a;
                    s2_d        = s1_q;
                    s3_d        = s2_q;
                    out_sys_d   = in_bit;
                    out_par_d   = fb_a ^ s1_q ^ s3_q;
                    out_tail_d  = 1'b0;
                    out_last_d  = 1'b0;
                    out_valid_d = 1'b1;
                    cnt_d       = cnt_q + LW'(1);
                    if (cnt_q + LW'(1) == k_q) begin
                        state_d = TAIL;
                    end
                end
            end
            TAIL: begin
                // Feedback input cancels the feedback sum, so a = 0 and the trellis drains to 000.
                if (load_ok) begin
                    s1_d        = 1'b0;
                    s2_d        = s1_q;
                    s3_d        = s2_q;
                    out_sys_d   = s2_q ^ s3_q;
                    out_par_d   = s1_q ^ s3_q;
                    out_tail_d  = 1'b1;
                    out_last_d  = (tail_cnt_q == 2'd2);
                    out_valid_d = 1'b1;
                    tail_cnt_d  = tail_cnt_q + 2'd1;
                    if (tail_cnt_q == 2'd2) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (out_valid_q && out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= IDLE;
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            s3_q        <= 1'b0;
            cnt_q       <= '0;
            k_q         <= '0;
            tail_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_sys_q   <= 1'b0;
            out_par_q   <= 1'b0;
            out_tail_q  <= 1'b0;
            out_last_q  <= 1'b0;
            len_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            s3_q        <= s3_d;
            cnt_q       <= cnt_d;
            k_q         <= k_d;
            tail_cnt_q  <= tail_cnt_d;
            out_valid_q <= out_valid_d;
            out_sys_q   <= out_sys_d;
            out_par_q   <= out_par_d;
            out_tail_q  <= out_tail_d;
            out_last_q  <= out_last_d;
            len_err_q   <= len_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sys   = out_sys_q;
    assign out_par   = out_par_q;
    assign out_tail  = out_tail_q;
    assign out_last  = out_last_q;
    assign len_err   = len_err_q;

endmodule

// File: doc/rsc_encoder.md
RSC_ENCODER -- requirements
Module: rsc_encoder

Interface
REQ-001 SHALL have parameter KMAX, default 6144: maximum frame length in information bits.
REQ-002 SHALL have parameter LW, default 13: width of the frame_len port; 2^LW > KMAX.
REQ-003 SHALL have port Clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: frame-start request, sampled only in IDLE.
REQ-006 SHALL have port frame_len, input, LW bits: information-bit count K, sampled with start.
REQ-007 SHALL have port len_err, output, 1 bit: one-cycle pulse when a start is rejected.
REQ-008 SHALL have port in_valid, input, 1 bit: in_bit holds valid data.
REQ-009 SHALL have port in_ready, output, 1 bit: the encoder accepts in_bit this cycle.
REQ-010 SHALL have port in_bit, input, 1 bit: information bit u_k.
REQ-011 SHALL have port out_valid, output, 1 bit: the output pair is valid.
REQ-012 SHALL have port out_ready, input, 1 bit: downstream accepts the pair.
REQ-013 SHALL have port out_sys, output, 1 bit: systematic bit x_k (tail: feedback input).
REQ-014 SHALL have port out_par, output, 1 bit: parity bit z_k.
REQ-015 SHALL have port out_tail, output, 1 bit: the current pair is a termination pair.
REQ-016 SHALL have port out_last, output, 1 bit: the current pair is the final (third) tail pair.
REQ-017 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-018 SHALL implement the LTE constituent RSC code with registers s1, s2, s3: a = u^s2^s3; z = a^s1^s3; next state s1<=a, s2<=s1, s3<=s2.
REQ-019 SHALL use an FSM with states IDLE, DATA, TAIL and FLUSH.
REQ-020 SHALL behave as follows in IDLE when start=1: if 40<=frame_len<=KMAX, latch K, clear s1..s3 and the counter, and go to DATA; otherwise pulse len_err for one cycle and stay in IDLE.
REQ-021 SHALL drive in_ready = (state==DATA) && (!out_valid || out_ready).
REQ-022 SHALL do all of the following on an input transfer (in_valid && in_ready): compute a and z, update s1..s3, load the output register with out_sys=u, out_par=z, out_tail=0, set out_valid=1, and increment the counter.
REQ-023 SHALL go from DATA to TAIL after the transfer that brings the counter to K.
REQ-024 SHALL, in TAIL, emit three pairs, each when !out_valid || out_ready, using u=s2^s3 (so a=0): out_sys=s2^s3, out_par=s1^s3, out_tail=1; out_last=1 on the third pair only.
REQ-025 SHALL go from TAIL to FLUSH after the third tail pair is loaded; s1..s3 SHALL then be 000.
REQ-026 SHALL, in FLUSH, go to IDLE once the last pair is accepted (out_valid && out_ready), clearing out_valid in that cycle.
REQ-027 SHALL hold out_sys, out_par, out_tail and out_last stable while out_valid && !out_ready.
REQ-028 SHALL, when an accept and a new load occur in the same cycle, take the new load (full throughput, one pair per cycle).
REQ-029 SHALL ignore start outside IDLE and SHALL NOT pulse len_err for it.
REQ-030 SHALL give a latency of one cycle from input transfer to out_valid; K+3 output pairs per frame.
REQ-031 SHALL allow a new frame to start in the cycle after FLUSH exits to IDLE.

Reset
REQ-032 SHALL, while Reset=1 (including mid-frame), go to IDLE and set s1..s3=000, counter=0, out_valid=0, out_sys=0, out_par=0, out_tail=0, out_last=0, len_err=0, busy=0 and in_ready=0.
REQ-033 SHALL give Reset priority over start and over every handshake in the same cycle.

Verification
REQ-034 SHALL cover the case K=40, all u=0, out_ready=1: 43 pairs, all sys and par bits 0, out_tail on pairs 41-43, out_last on pair 43, busy low afterwards.
REQ-035 SHALL cover the case K=40, u0=1 and all other u=0: out_par for pairs 0-4 = 1,1,1,1,0; s1..s3=000 after the tail; the tail pairs match REQ-024 computed from the state after u39.
REQ-036 SHALL cover the cases frame_len=39 and frame_len=KMAX+1 with start: len_err pulses for one cycle, busy stays 0, in_ready stays 0.
REQ-037 SHALL cover backpressure with out_ready toggled randomly on a random K=64 frame: output matches the golden model, the pair stays stable while stalled, and in_ready=0 whenever out_valid && !out_ready.
REQ-038 SHALL cover Reset asserted at data bit 20, followed by a new start with K=40: outputs are as in REQ-032 in the cycle after reset, and the second frame matches the golden model with state starting at 000.
REQ-039 SHALL cover two back-to-back frames (K=40, then K=KMAX): exactly 43 and KMAX+3 pairs, and start asserted during the first frame is ignored.
